// File: rtl/bus_grant_mux.sv
// rtl/bus_grant_mux.sv - grant-driven burst mux from four masters onto one slave port
module bus_grant_mux #(
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt0,
    input  logic          gnt1,
    input  logic          gnt2,
    input  logic          gnt3,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    input  logic [DW-1:0] wdata3,
    input  logic          we0,
    input  logic          we1,
    input  logic          we2,
    input  logic          we3,
    input  logic [1:0]    len0,
    input  logic [1:0]    len1,
    input  logic [1:0]    len2,
    input  logic [1:0]    len3,
    input  logic          slv_ready,
    output logic          slv_valid,
    output logic [AW-1:0] slv_addr,
    output logic [DW-1:0] slv_wdata,
    output logic          slv_we,
    output logic          done0,
    output logic          done1,
    output logic          done2,
    output logic          done3,
    output logic          busy,
    output logic          err
);

    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          err_nx;
    logic [1:0]    owner;
    logic [1:0]    beat;
    logic [1:0]    len_q;
    logic [AW-1:0] base;
    logic          we_q;
    logic [TW-1:0] tmo_cnt;

    logic [2:0]    gnt_cnt;
    logic          one_hot;
    logic          collide;
    logic [1:0]    sel;
    logic [AW-1:0] addr_sel;
    logic          we_sel;
    logic [1:0]    len_sel;
    logic [DW-1:0] wdata_own;
    logic          in_xfer;
    logic          beat_ok;
    logic          last_beat;
    logic          tmo_hit;

    assign gnt_cnt   = {2'b0, gnt0} + {2'b0, gnt1} + {2'b0, gnt2} + {2'b0, gnt3};
    assign one_hot   = (gnt_cnt == 3'd1);
    assign collide   = (gnt_cnt > 3'd1);
    assign in_xfer   = (state == XFER);
    assign beat_ok   = in_xfer && slv_ready;
    assign last_beat = (beat == len_q);
    assign tmo_hit   = in_xfer && !slv_ready && (tmo_cnt == TW'(TMO - 1));

    // Encode the one-hot grant into a master index (only meaningful when one_hot).
    always_comb begin
        sel = 2'd0;
        if (gnt1) sel = 2'd1;
        if (gnt2) sel = 2'd2;
        if (gnt3) sel = 2'd3;
    end

    // Select the granted master's burst parameters for latching.
    always_comb begin
        addr_sel = addr0;
        we_sel   = we0;
        len_sel  = len0;
        case (sel)
            2'd1:    begin addr_sel = addr1; we_sel = we1; len_sel = len1; end
            2'd2:    begin addr_sel = addr2; we_sel = we2; len_sel = len2; end
            2'd3:    begin addr_sel = addr3; we_sel = we3; len_sel = len3; end
            default: begin addr_sel = addr0; we_sel = we0; len_sel = len0; end
        endcase
    end

    // Live write data of the current owner; the slave sees it without a register stage.
    always_comb begin
        case (owner)
            2'd1:    wdata_own = wdata1;
            2'd2:    wdata_own = wdata2;
            2'd3:    wdata_own = wdata3;
            default: wdata_own = wdata0;
        endcase
    end

    // Next-state and error-pulse decode.
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_nx = XFER;
                end else if (collide) begin
                    err_nx = 1'b1;
                end
            end
            XFER: begin
                if (beat_ok && last_beat) begin
                    state_nx = DONE;
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= err_nx;
        end
    end

    // Burst context: latched on a clean grant, advanced per completed beat, stall counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 2'd0;
            base    <= '0;
            we_q    <= 1'b0;
            len_q   <= 2'd0;
            beat    <= 2'd0;
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            if (one_hot) begin
                owner   <= sel;
                base    <= addr_sel;
                we_q    <= we_sel;
                len_q   <= len_sel;
                beat    <= 2'd0;
                tmo_cnt <= '0;
            end
        end else if (in_xfer) begin
            if (slv_ready) begin
                tmo_cnt <= '0;
                if (!last_beat) begin
                    beat <= beat + 2'd1;
                end
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign slv_valid = in_xfer;
    assign slv_addr  = in_xfer ? (base + AW'(beat)) : '0;
    assign slv_we    = in_xfer && we_q;
    assign slv_wdata = in_xfer ? wdata_own : '0;
    assign busy      = (state != IDLE);
    assign done0     = (state == DONE) && (owner == 2'd0);
    assign done1     = (state == DONE) && (owner == 2'd1);
    assign done2     = (state == DONE) && (owner == 2'd2);
    assign done3     = (state == DONE) && (owner == 2'd3);

endmodule

// File: doc/bus_grant_mux.md
BUS_GRANT_MUX -- requirements
Module: bus_grant_mux

Interface
REQ-001 Parameter AW, default 8: address width of every master port and the slave port.
REQ-002 Parameter DW, default 8: write-data width of every master port and the slave port.
REQ-003 Parameter TMO, default 15: slave-stall timeout, in cycles.
REQ-004 clk  in  1  single clock; every flop in the block SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 gnt0..gnt3  in  1 each  one-hot grant from the upstream 4-way arbiter.
REQ-007 addr0..addr3  in  AW each  start address of each master's burst.
REQ-008 wdata0..wdata3  in  DW each  write data of each master, driven live during the burst.
REQ-009 we0..we3  in  1 each  write enable of each master (1 = write, 0 = read).
REQ-010 len0..len3  in  2 each  burst length of each master, encoded as number of beats minus 1.
REQ-011 slv_ready  in  1  slave accepts the current beat.
REQ-012 slv_valid  out  1  a beat is presented to the slave.
REQ-013 slv_addr  out  AW  address of the current beat.
REQ-014 slv_wdata  out  DW  write data of the current beat.
REQ-015 slv_we  out  1  write enable of the current beat.
REQ-016 done0..done3  out  1 each  one-cycle completion pulse to the owning master.
REQ-017 busy  out  1  block is in XFER or DONE.
REQ-018 err  out  1  one-cycle pulse on grant collision or slave timeout.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, XFER and DONE.
REQ-020 In IDLE, if exactly one gntN is high at a clock edge, the block SHALL latch owner=N, base=addrN, we=weN, len=lenN, clear beat and the timeout counter, and enter XFER.
REQ-021 In IDLE, if two or more gnt lines are high, the block SHALL pulse err for one cycle, stay in IDLE and latch nothing.
REQ-022 In IDLE, if all gnt lines are low, the block SHALL stay in IDLE.
REQ-023 slv_valid SHALL rise on the cycle after the grant edge (one-cycle latency).
REQ-024 In XFER, slv_valid SHALL be 1, slv_addr SHALL be (base + beat) mod 2^AW, slv_we SHALL be the latched we, and slv_wdata SHALL be wdata[owner] muxed combinationally from the live input.
REQ-025 In XFER, gnt inputs and the inputs of non-owner masters SHALL be ignored.
REQ-026 Beat handshake: a beat completes at a clock edge where slv_valid=1 and slv_ready=1; after completion, beat SHALL increment if beat<len, otherwise the block SHALL enter DONE.
REQ-027 Address increment SHALL wrap modulo 2^AW, e.g. base=0xFF with len=1 SHALL produce addresses 0xFF then 0x00.
REQ-028 Timeout counter: it SHALL increment on every XFER cycle with slv_ready=0 and clear on every completed beat.
REQ-029 When the timeout counter reaches TMO with slv_ready still 0, the block SHALL pulse err for one cycle, return to IDLE, drop slv_valid, and assert no done pulse.
REQ-030 In DONE, done[owner] SHALL be 1 for exactly one cycle, the other done lines SHALL be 0, slv_valid SHALL be 0, and the next state SHALL be IDLE.
REQ-031 Grants present during DONE SHALL be ignored, so the minimum spacing between bursts is len+3 cycles.
REQ-032 busy SHALL be 1 in XFER and DONE and 0 in IDLE.
REQ-033 When not in XFER, slv_addr, slv_wdata and slv_we SHALL be 0.
REQ-034 All outputs except slv_wdata SHALL be registered or decoded from registered state only.

Reset
REQ-035 While rst=1 at a clock edge, the state SHALL become IDLE and beat, timeout counter, owner, base, len and we SHALL become 0.
REQ-036 One cycle after rst=1 at a clock edge, slv_valid, busy, err and done0..done3 SHALL all be 0.
REQ-037 Reset asserted mid-burst SHALL abort the burst with no done and no err pulse; rst SHALL take priority over every other input.

Verification
REQ-038 Single grant: gnt2=1 for one cycle, addr2=0x10, len2=3, slv_ready=1 constantly -> slv_addr 0x10, 0x11, 0x12, 0x13 on four consecutive cycles, then done2 pulses for one cycle, busy is high for 5 cycles.
REQ-039 Stall: gnt0 with len0=0, slv_ready low for 5 cycles then high -> slv_valid and slv_addr held for 6 cycles, one beat completes, done0 pulses, err stays 0.
REQ-040 Timeout: gnt1 with slv_ready held at 0 -> err pulses after 15 stalled cycles, block returns to IDLE, done1 never pulses.
REQ-041 Collision and wrap: gnt0=gnt3=1 -> err pulse and busy stays 0; then gnt3 alone with addr3=0xFF, len3=1 -> slv_addr 0xFF then 0x00.
REQ-042 Reset mid-burst: rst=1 during beat 2 of a 4-beat burst -> next cycle slv_valid=0, busy=0, no done; a new grant afterwards completes normally.
